wait_state_memory: RTL and testbench
====================================

WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

Interface
REQ-001 Parameter MEMORY_FILE, default "", hex image loaded at elaboration when non-empty; contents otherwise undefined.
REQ-002 Parameter MEMORY_SIZE, default 4096, depth in words.
REQ-003 Parameter DATA_WIDTH, default 32, word width; legal values 8, 16, 32, 64.
REQ-004 Parameter WAIT_STATES, default 0, extra cycles per access; legal range 0..15.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rd_en_i  input  1  read request.
REQ-008 wr_en_i  input  1  write request.
REQ-009 addr_i  input  32  byte address.
REQ-010 data_i  input  DATA_WIDTH  write data.
REQ-011 be_i  input  DATA_WIDTH/8  byte-lane write strobes; bit k selects data_i[8k+7:8k].
REQ-012 data_o  output  DATA_WIDTH  read data, registered.
REQ-013 ack_o  output  1  one-cycle completion pulse, registered.
REQ-014 busy_o  output  1  high while an accepted access is in its wait phase.
REQ-015 err_o  output  1  error flag, pulses with ack_o (see REQ-030).

Function
REQ-016 States: IDLE, WAIT; request accepted only at an edge where state is IDLE, rst low and rd_en_i or wr_en_i high.
REQ-017 Read wins when rd_en_i and wr_en_i are both high at acceptance; the write is dropped, not queued.
REQ-018 At acceptance: addr_i, data_i, be_i and operation latched; later input changes have no effect on that access.
REQ-019 WAIT_STATES=0: access completes at the acceptance edge; ack_o high the following cycle; state stays IDLE.
REQ-020 WAIT_STATES=N>0: acceptance loads counter with N-1 and enters WAIT; counter decrements each edge; at edge where counter is 0, access completes and state returns to IDLE.
REQ-021 Latency: access accepted at edge E completes at edge E+WAIT_STATES; ack_o high exactly in the cycle after the completion edge, one cycle wide.
REQ-022 busy_o high exactly while state is WAIT; requests presented while busy_o is high are ignored, never buffered.
REQ-023 Back-to-back: new request accepted at the completion edge's following edge (ack_o-high cycle counts as IDLE); WAIT_STATES=0 sustains one access per cycle.
REQ-024 Word index = addr_i >> log2(DATA_WIDTH/8), taken modulo MEMORY_SIZE (upper index bits discarded; out-of-range addresses wrap, no error).
REQ-025 Write completion updates only lanes with be_i bit set; be_i all-zero write still acks, memory unchanged.
REQ-026 Read completion loads data_o with addressed word; write returns ack_o only.
REQ-027 data_o holds its last read value through write acks and idle cycles until the next read completion.
REQ-028 Read of a word written by an earlier completed access returns the new value (no stale data).

Reset
REQ-029 rst high at an edge: state IDLE, counter 0, ack_o 0, busy_o 0, err_o 0, data_o 0; memory array not cleared; rst mid-WAIT aborts the access: pending write not committed, no ack_o issued.

Configuration
REQ-030 Macro WAIT_STATE_MEMORY_ALIGN_CHECK_EN defined: access with nonzero addr_i low log2(DATA_WIDTH/8) bits is misaligned; it runs normal latency, ack_o and err_o pulse together, write suppressed, data_o loaded with 0 on read.
REQ-031 Macro undefined: address low bits ignored, misaligned access behaves as aligned, err_o tied 0.

Verification
REQ-032 WAIT_STATES=0, write 0xDEADBEEF to 0x10 be=0xF, read 0x10 next cycle -> ack_o each cycle after acceptance, data_o=0xDEADBEEF, busy_o never high.
REQ-033 WAIT_STATES=3, read accepted at edge E -> busy_o high 3 cycles, ack_o high only in cycle after E+3, rd_en_i pulses during busy ignored.
REQ-034 Word 0x20 = 0x11223344, write 0xAABBCCDD be=0b0101, read -> 0x11BB33DD.
REQ-035 MEMORY_SIZE=4096, DATA_WIDTH=32, write 0x5A5A5A5A to 0x4000, read 0x0 -> 0x5A5A5A5A (wrap); rd_en_i and wr_en_i both high -> read performed, memory unchanged.
REQ-036 WAIT_STATES=4, write accepted, rst pulsed 2 cycles later, then read same address -> no ack for write, old value returned; with WAIT_STATE_MEMORY_ALIGN_CHECK_EN, read at 0x13 -> ack_o and err_o together, data_o=0.

Source files
------------

// File: rtl/wait_state_memory.sv
// -----------------------------------------------------------------------------
// wait_state_memory
//
// Single-port word memory with a programmable number of wait states per
// access. A request is accepted only while the FSM is idle; it then takes
// WAIT_STATES further edges to complete, after which ack_o pulses for one
// cycle. Requests arriving while busy are dropped, never buffered.
//
// Parameters:
//   MEMORY_FILE  hex image loaded at elaboration when non-empty
//   MEMORY_SIZE  depth in words
//   DATA_WIDTH   word width (8, 16, 32 or 64)
//   WAIT_STATES  extra cycles per access (0..15)
//
// Ports:
//   clk      clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   rd_en_i  read request (wins over a simultaneous write)
//   wr_en_i  write request
//   addr_i   byte address; word index = (addr_i >> log2(bytes)) mod depth
//   data_i   write data
//   be_i     byte-lane write strobes
//   data_o   registered read data, held until the next read completes
//   ack_o    one-cycle completion pulse
//   busy_o   high while an accepted access is in its wait phase
//   err_o    misalignment error, pulses with ack_o
//
// Optional feature macro: WAIT_STATE_MEMORY_ALIGN_CHECK_EN
//   When defined, accesses whose address low bits are nonzero complete with
//   err_o set, suppress the write and return zero on a read. When undefined,
//   the low address bits are ignored and err_o is tied low.
// -----------------------------------------------------------------------------
module wait_state_memory #(
  parameter string       MEMORY_FILE = "",
  parameter int unsigned MEMORY_SIZE = 4096,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en_i,
  input  logic                    wr_en_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ack_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned LANES    = DATA_WIDTH / 8;
  localparam int unsigned OFFS     = $clog2(LANES);
  localparam int unsigned AW       = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  logic [DATA_WIDTH-1:0] mem [MEMORY_SIZE];

  state_t state;
  logic [3:0] cnt;

  // Operands captured at acceptance for the wait phase
  logic                  lat_rd;
  logic [AW-1:0]         lat_idx;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [LANES-1:0]      lat_be;
  logic                  lat_mis;

  // Decoded request
  logic        req;
  logic        accept;
  logic [31:0] word_addr;
  logic [AW-1:0] req_idx;
  logic        req_mis;

  // Access completing at this edge
  logic                  cmp_en;
  logic                  cmp_rd;
  logic                  cmp_mis;
  logic [AW-1:0]         cmp_idx;
  logic [DATA_WIDTH-1:0] cmp_data;
  logic [LANES-1:0]      cmp_be;

  always_comb begin
    req       = rd_en_i | wr_en_i;
    accept    = (state == IDLE) && req;
    word_addr = addr_i >> OFFS;
    req_idx   = AW'(word_addr % MEMORY_SIZE);
`ifdef WAIT_STATE_MEMORY_ALIGN_CHECK_EN
    req_mis   = (addr_i & 32'(LANES - 1)) != '0;
`else
    req_mis   = 1'b0;
`endif

    // With no wait states the access completes on the acceptance edge using
    // the live inputs; otherwise it completes from the latched copy.
    if (WAIT_STATES == 0) begin
      cmp_en   = accept;
      cmp_rd   = rd_en_i;
      cmp_mis  = req_mis;
      cmp_idx  = req_idx;
      cmp_data = data_i;
      cmp_be   = be_i;
    end else begin
      cmp_en   = (state == WAIT) && (cnt == '0);
      cmp_rd   = lat_rd;
      cmp_mis  = lat_mis;
      cmp_idx  = lat_idx;
      cmp_data = lat_data;
      cmp_be   = lat_be;
    end
  end

  // Memory array: never cleared by reset; a reset edge cancels any commit.
  always_ff @(posedge clk) begin
    if (!rst && cmp_en && !cmp_rd && !cmp_mis) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (cmp_be[k]) begin
          mem[cmp_idx][8*k +: 8] <= cmp_data[8*k +: 8];
        end
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ack_o    <= 1'b0;
      busy_o   <= 1'b0;
      data_o   <= '0;
      lat_rd   <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
      lat_be   <= '0;
      lat_mis  <= 1'b0;
    end else begin
      ack_o <= cmp_en;
      if (cmp_en && cmp_rd) begin
        data_o <= cmp_mis ? '0 : mem[cmp_idx];
      end

      case (state)
        IDLE: begin
          if (accept && (WAIT_STATES != 0)) begin
            state    <= WAIT;
            busy_o   <= 1'b1;
            cnt      <= CNT_LOAD;
            lat_rd   <= rd_en_i;
            lat_idx  <= req_idx;
            lat_data <= data_i;
            lat_be   <= be_i;
            lat_mis  <= req_mis;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef WAIT_STATE_MEMORY_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= cmp_en & cmp_mis;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wait_state_memory.sv
// -----------------------------------------------------------------------------
// tb_wait_state_memory
//
// Three instances (WAIT_STATES = 0, 3, 4) share one stimulus stream. A
// transaction-level model predicts each instance's outputs from acceptance
// and completion times; a negedge process compares every cycle. Directed
// literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wait_state_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din  = '0;
  logic [3:0]  be   = '0;

  logic [31:0] dout [3];
  logic        ack  [3];
  logic        busy [3];
  logic        err  [3];

  int ws_tab [3] = '{0, 3, 4};

  always #5 clk = ~clk;

  wait_state_memory #(.MEMORY_FILE(""), .MEMORY_SIZE(4096), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .rd_en_i(rd), .wr_en_i(wr), .addr_i(addr), .data_i(din), .be_i(be),
    .data_o(dout[0]), .ack_o(ack[0]), .busy_o(busy[0]), .err_o(err[0]));

  wait_state_memory #(.MEMORY_FILE(""), .MEMORY_SIZE(4096), .DATA_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .rd_en_i(rd), .wr_en_i(wr), .addr_i(addr), .data_i(din), .be_i(be),
    .data_o(dout[1]), .ack_o(ack[1]), .busy_o(busy[1]), .err_o(err[1]));

  wait_state_memory #(.MEMORY_FILE(""), .MEMORY_SIZE(4096), .DATA_WIDTH(32), .WAIT_STATES(4)) u_ws4 (
    .clk(clk), .rst(rst), .rd_en_i(rd), .wr_en_i(wr), .addr_i(addr), .data_i(din), .be_i(be),
    .data_o(dout[2]), .ack_o(ack[2]), .busy_o(busy[2]), .err_o(err[2]));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

`ifdef WAIT_STATE_MEMORY_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // ---------------- transaction model ----------------
  logic [31:0] mmem [int];       // key = instance*4096 + word index
  bit          p_v    [3];
  int          p_done [3];
  bit          p_rd   [3];
  logic [31:0] p_addr [3];
  logic [31:0] p_data [3];
  logic [3:0]  p_be   [3];
  logic [31:0] e_data [3];
  bit          e_ack  [3];
  bit          e_busy [3];
  bit          e_err  [3];
  bit          mvalid = 1'b0;
  int          edge_n = 0;
  bit          busy0_seen = 1'b0;

  function automatic int key_of(input int i, input logic [31:0] a);
    return i * 4096 + int'((a / 4) % 4096);
  endfunction

  function automatic logic [31:0] mread(input int key);
    if (mmem.exists(key)) return mmem[key];
    return 'x;
  endfunction

  task automatic complete(input int i);
    bit          mis;
    int          k;
    logic [31:0] w;
    mis = ALIGN_EN && ((p_addr[i] % 4) != 0);
    k = key_of(i, p_addr[i]);
    e_ack[i] = 1'b1;
    e_err[i] = mis;
    if (p_rd[i]) begin
      e_data[i] = mis ? 32'h0 : mread(k);
    end else if (!mis) begin
      w = mread(k);
      for (int j = 0; j < 4; j++)
        if (p_be[i][j]) w[8*j +: 8] = p_data[i][8*j +: 8];
      mmem[k] = w;
    end
  endtask

  // Advance the model across the coming edge using the inputs now stable.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      e_ack[i] = 1'b0;
      e_err[i] = 1'b0;
      if (rst) begin
        p_v[i]    = 1'b0;
        e_busy[i] = 1'b0;
        e_data[i] = 32'h0;
      end else begin
        if (!p_v[i] && (rd || wr)) begin
          p_v[i]    = 1'b1;
          p_done[i] = edge_n + ws_tab[i];
          p_rd[i]   = rd;
          p_addr[i] = addr;
          p_data[i] = din;
          p_be[i]   = be;
        end
        if (p_v[i] && p_done[i] == edge_n) begin
          complete(i);
          p_v[i] = 1'b0;
        end
        e_busy[i] = p_v[i];
      end
    end
    edge_n++;
    mvalid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      busy0_seen |= busy[0];
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ack[%0d]@%0d", i, edge_n), 32'(ack[i]), 32'(e_ack[i]));
        check($sformatf("busy[%0d]@%0d", i, edge_n), 32'(busy[i]), 32'(e_busy[i]));
        check($sformatf("err[%0d]@%0d", i, edge_n), 32'(err[i]), 32'(e_err[i]));
        if (^e_data[i] !== 1'bx)
          check($sformatf("data[%0d]@%0d", i, edge_n), dout[i], e_data[i]);
      end
    end
    step();
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; din = d; be = b;
  endtask

  // Deassert and scramble data/address: must not disturb a latched access.
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
  endtask

  task automatic req(input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    drive(r, w, a, d, b);
    idle(7);
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } vec_t;

  vec_t tbl [10] = '{
    '{1'b0, 1'b1, 32'h100,  32'hCAFEF00D, 4'hF},
    '{1'b1, 1'b0, 32'h100,  32'h0,        4'h0},
    '{1'b0, 1'b1, 32'h104,  32'h01020304, 4'hF},
    '{1'b0, 1'b1, 32'h104,  32'hA0B0C0D0, 4'hC},
    '{1'b1, 1'b0, 32'h104,  32'h0,        4'h0},
    '{1'b1, 1'b1, 32'h100,  32'h0,        4'hF},
    '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0},
    '{1'b0, 1'b1, 32'h4100, 32'h600DF00D, 4'h3},
    '{1'b1, 1'b0, 32'h100,  32'h0,        4'h0},
    '{1'b1, 1'b0, 32'h104,  32'h0,        4'h0}
  };

  int n_busy1, n_ack1, n_ack0, n_ack2;

  initial begin
    // Reset values after the first reset edge
    @(negedge clk);
    check("rst data_o", dout[0], 32'h0);
    check("rst ack_o", 32'(ack[1]), 32'h0);
    check("rst busy_o", 32'(busy[2]), 32'h0);
    check("rst err_o", 32'(err[2]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back-to-back (no wait states sustain one per cycle)
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("b2b read data ws0", dout[0], 32'hDEADBEEF);
    check("b2b read ack ws0", 32'(ack[0]), 32'h1);
    idle(7);

    // Read under WAIT_STATES=3 with a stray read pulse while busy
    n_busy1 = 0; n_ack1 = 0; n_ack0 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0 || i == 2, 1'b0, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      n_busy1 += int'(busy[1]);
      n_ack1  += int'(ack[1]);
      n_ack0  += int'(ack[0]);
    end
    check("ws3 busy cycles", 32'(n_busy1), 32'd3);
    check("ws3 ack count", 32'(n_ack1), 32'd1);
    check("ws0 ack count", 32'(n_ack0), 32'd2);
    check("ws3 read data", dout[1], 32'hDEADBEEF);
    idle(4);

    // Byte-lane merge, then an all-zero strobe write
    req(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    req(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    check("lane merge ws4", dout[2], 32'h11BB33DD);
    req(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    check("be zero ws0", dout[0], 32'h11BB33DD);

    // Address wrap and read-over-write priority
    req(1'b0, 1'b1, 32'h4000, 32'h5A5A5A5A, 4'hF);
    req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    check("wrap ws0", dout[0], 32'h5A5A5A5A);
    req(1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
    check("rd+wr returns read ws3", dout[1], 32'h5A5A5A5A);
    req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    check("rd+wr no write ws4", dout[2], 32'h5A5A5A5A);

    // Reset in the middle of a pending write
    req(1'b0, 1'b1, 32'h30, 32'h13572468, 4'hF);
    n_ack0 = 0; n_ack1 = 0; n_ack2 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 32'h30, 32'h99999999, 4'hF);
      else        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst = (i == 2);
      @(negedge clk);
      n_ack0 += int'(ack[0]);
      n_ack1 += int'(ack[1]);
      n_ack2 += int'(ack[2]);
    end
    check("abort ack ws4", 32'(n_ack2), 32'd0);
    check("abort ack ws3", 32'(n_ack1), 32'd0);
    check("abort ack ws0", 32'(n_ack0), 32'd1);
    req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    check("abort old value ws4", dout[2], 32'h13572468);
    check("abort old value ws3", dout[1], 32'h13572468);
    check("committed ws0", dout[0], 32'h99999999);

    // Misaligned read and write at word 0x10
    drive(1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("misaligned ack", 32'(ack[0]), 32'h1);
    check("misaligned err", 32'(err[0]), 32'(ALIGN_EN));
    check("misaligned data", dout[0], ALIGN_EN ? 32'h0 : 32'hDEADBEEF);
    idle(7);
    req(1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF);
    req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("misaligned write", dout[0], ALIGN_EN ? 32'hDEADBEEF : 32'hFFFFFFFF);

    // Dense back-to-back vector stream, checked by the model only
    foreach (tbl[i]) drive(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b);
    idle(10);
    check("ws0 never busy", 32'(busy0_seen), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
